// File: rtl/stream_sink_pkg.sv
// Shared types, constants and helpers for the stream pattern sink and its
// LFSR throttle. Pattern sources that reuse the LFSR import the same package.
package stream_sink_pkg;

  // Packet framing state of the sink.
  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  // Feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11).
  // Bit 15 is tap 16, bit 13 is tap 14, bit 12 is tap 13 and bit 10 is tap 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest counter the saturating helper handles.
  localparam int SAT_MAX_WIDTH = 64;

  // Saturating increment of the low 'width' bits of 'value'.
  // Once the value reaches all ones in that width it stays there.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [SAT_MAX_WIDTH-1:0] limit;
    if (width >= SAT_MAX_WIDTH) begin
      limit = '1;
    end else begin
      limit = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
    end
    if (value >= limit) begin
      sat_inc = limit;
    end else begin
      sat_inc = value + SAT_MAX_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/stream_channel.sv
// AXI-Stream style channel bundle.
// Handshake: a beat transfers on a rising clock edge where t_valid and t_ready
// are both high. The master holds t_data/t_keep/t_strb/t_last/t_id/t_dest/
// t_user stable while t_valid is high and t_ready is low, and may not drop
// t_valid until the beat transfers. The slave may raise or lower t_ready at
// any time, independently of t_valid.
interface stream_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  t_valid;
  logic                  t_ready;
  logic [DATA_WIDTH-1:0] t_data;
  logic [KEEP_WIDTH-1:0] t_keep;
  logic [KEEP_WIDTH-1:0] t_strb;
  logic                  t_last;
  logic [ID_WIDTH-1:0]   t_id;
  logic [DEST_WIDTH-1:0] t_dest;
  logic [USER_WIDTH-1:0] t_user;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    output t_ready
  );

endinterface

// File: rtl/stream_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting toward the MSB with the feedback bit entering
// at bit 0. Used as a cheap pseudo-random source for throttling and patterns.
module stream_lfsr16
  import stream_sink_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic        feedback;

  // Parity of the tapped bits forms the new low bit.
  assign feedback = ^(lfsr_q & LFSR_TAPS);

  // Shift register; the seed must be nonzero or the sequence locks up.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= SEED;
    end else if (enable) begin
      lfsr_q <= {lfsr_q[14:0], feedback};
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/stream_pattern_sink.sv
// AXI-Stream slave that throttles t_ready pseudo-randomly and checks every
// accepted beat against an incrementing counter that restarts at 0 for each
// packet. Keeps saturating word/packet/error counts and the first bad word.
module stream_pattern_sink
  import stream_sink_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  stream_channel.slave          master,
  input  logic [7:0]            ready_rate,
  input  logic                  check_en,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output state_e                state
);

  logic [15:0]           lfsr;
  logic                  ready_q;
  logic                  beat;
  logic                  take;
  logic                  pkt_end;
  logic                  mismatch;
  logic [CNT_WIDTH-1:0]  expected;
  logic [DATA_WIDTH-1:0] pattern;
  state_e                state_q;
  state_e                state_d;

  // Sideband fields carry no meaning for this sink.
  logic unused_sideband;
  assign unused_sideband = ^{master.t_id, master.t_dest, master.t_user};

  stream_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .enable  (1'b1),
    .state   (lfsr)
  );

  // Registered throttle: ready for the next cycle from the current LFSR value.
  // 8'hFF is forced to always-ready since lfsr[7:0] < 255 misses one value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (ready_rate == 8'hFF) | (lfsr[7:0] < ready_rate);
    end
  end

  assign master.t_ready = ready_q;

  // A transfer this cycle; clear in the same cycle discards it entirely.
  assign beat = master.t_valid & ready_q;
  assign take = beat & ~clear;

  // The expected counter zero-extended to the bus width.
  assign pattern  = DATA_WIDTH'(expected);
  assign mismatch = check_en &
                    ((master.t_data != pattern) |
                     ~(&master.t_keep) |
                     ~(&master.t_strb));

  // Framing state register; clear returns to the between-packets state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next framing state from accepted beats and their t_last.
  always_comb begin
    state_d = state_q;
    if (take) begin
      case (state_q)
        IDLE:    if (!master.t_last) state_d = BODY;
        BODY:    if (master.t_last)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Framing outputs: visible state and the end-of-packet strobe.
  always_comb begin
    state   = state_q;
    pkt_end = take & master.t_last;
  end

  // Expected value: advances on every accepted beat, even a bad one,
  // and restarts at 0 after the last beat of a packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      expected <= '0;
    end else if (clear) begin
      expected <= '0;
    end else if (take) begin
      if (pkt_end) begin
        expected <= '0;
      end else begin
        expected <= expected + CNT_WIDTH'(1);
      end
    end
  end

  // Saturating word and packet counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else if (clear) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else if (take) begin
      word_count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(word_count), CNT_WIDTH));
      if (pkt_end) begin
        pkt_count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(pkt_count), CNT_WIDTH));
      end
    end
  end

  // Error statistics: saturating count, sticky flag and the first bad word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_count      <= '0;
      err            <= 1'b0;
      first_err_data <= '0;
    end else if (clear) begin
      err_count      <= '0;
      err            <= 1'b0;
      first_err_data <= '0;
    end else if (take && mismatch) begin
      err_count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(err_count), CNT_WIDTH));
      err       <= 1'b1;
      if (!err) begin
        first_err_data <= master.t_data;
      end
    end
  end

endmodule

// File: tb/tb_stream_pattern_sink.sv
// Bench for stream_pattern_sink: a 32-bit-counter instance and a 4-bit-counter
// instance receive identical traffic; a reference model tracks both and is
// compared every cycle, with literal checks after each directed scenario.
module tb_stream_pattern_sink;
  import stream_sink_pkg::*;

  localparam int DW = 64;
  localparam int KW = DW / 8;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  logic [7:0] ready_rate;
  logic       check_en;
  logic       clear;

  stream_channel #(.DATA_WIDTH(DW)) ch_big ();
  stream_channel #(.DATA_WIDTH(DW)) ch_small ();

  logic [31:0]   wc_b, pc_b, ec_b;
  logic          err_b;
  logic [DW-1:0] fed_b;
  state_e        st_b;
  logic [3:0]    wc_s, pc_s, ec_s;
  logic          err_s;
  logic [DW-1:0] fed_s;
  state_e        st_s;

  stream_pattern_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .LFSR_SEED(16'hACE1)) dut_big (
    .aclk(aclk), .aresetn(aresetn), .master(ch_big), .ready_rate(ready_rate),
    .check_en(check_en), .clear(clear), .word_count(wc_b), .pkt_count(pc_b),
    .err_count(ec_b), .err(err_b), .first_err_data(fed_b), .state(st_b)
  );

  stream_pattern_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .LFSR_SEED(16'hACE1)) dut_small (
    .aclk(aclk), .aresetn(aresetn), .master(ch_small), .ready_rate(ready_rate),
    .check_en(check_en), .clear(clear), .word_count(wc_s), .pkt_count(pc_s),
    .err_count(ec_s), .err(err_s), .first_err_data(fed_s), .state(st_s)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic checking = 1'b0;
  int phase = 0;
  int rc_cyc = 0;
  int rc_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the 32-bit-counter sink, index 1 the 4-bit one.
  logic [63:0] m_max [2];
  logic [63:0] m_word [2], m_pkt [2], m_errc [2], m_exp [2], m_fed [2];
  logic        m_err [2], m_inpkt [2];
  logic [15:0] m_lfsr;
  logic        m_ready;

  initial begin
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 64'hF;
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < 2; k++) begin
        m_word[k] = 0; m_pkt[k] = 0; m_errc[k] = 0; m_exp[k] = 0;
        m_fed[k] = 0; m_err[k] = 1'b0; m_inpkt[k] = 1'b0;
      end
      m_lfsr  = 16'hACE1;
      m_ready = 1'b0;
    end else begin
      logic acc, bad;
      acc = ch_big.t_valid && m_ready;
      for (int k = 0; k < 2; k++) begin
        if (clear) begin
          m_word[k] = 0; m_pkt[k] = 0; m_errc[k] = 0; m_exp[k] = 0;
          m_fed[k] = 0; m_err[k] = 1'b0; m_inpkt[k] = 1'b0;
        end else if (acc) begin
          bad = check_en && ((ch_big.t_data != m_exp[k]) ||
                             (ch_big.t_keep != 8'hFF) || (ch_big.t_strb != 8'hFF));
          if (m_word[k] < m_max[k]) m_word[k] = m_word[k] + 1;
          if (ch_big.t_last && m_pkt[k] < m_max[k]) m_pkt[k] = m_pkt[k] + 1;
          if (bad) begin
            if (m_errc[k] < m_max[k]) m_errc[k] = m_errc[k] + 1;
            if (!m_err[k]) m_fed[k] = ch_big.t_data;
            m_err[k] = 1'b1;
          end
          m_exp[k]   = ch_big.t_last ? 64'd0 : ((m_exp[k] + 1) & m_max[k]);
          m_inpkt[k] = !ch_big.t_last;
        end
      end
      m_ready = (ready_rate == 8'hFF) || (m_lfsr[7:0] < ready_rate);
      m_lfsr  = lfsr_step(m_lfsr);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    if (checking) begin
      chk("ready_big",   64'(ch_big.t_ready),   64'(m_ready));
      chk("ready_small", 64'(ch_small.t_ready), 64'(m_ready));
      chk("word_big",  64'(wc_b),  m_word[0]);
      chk("pkt_big",   64'(pc_b),  m_pkt[0]);
      chk("errc_big",  64'(ec_b),  m_errc[0]);
      chk("err_big",   64'(err_b), 64'(m_err[0]));
      chk("fed_big",   fed_b,      m_fed[0]);
      chk("state_big", 64'(st_b == BODY), 64'(m_inpkt[0]));
      chk("word_small",  64'(wc_s),  m_word[1]);
      chk("pkt_small",   64'(pc_s),  m_pkt[1]);
      chk("errc_small",  64'(ec_s),  m_errc[1]);
      chk("err_small",   64'(err_s), 64'(m_err[1]));
      chk("fed_small",   fed_s,      m_fed[1]);
      chk("state_small", 64'(st_s == BODY), 64'(m_inpkt[1]));
      if (phase != 0) begin
        rc_cyc++;
        if (ch_big.t_ready) rc_rdy++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic v, input logic [63:0] d, input logic l,
                         input logic [7:0] keep, input logic [7:0] strb);
    ch_big.t_valid = v;   ch_small.t_valid = v;
    ch_big.t_data  = d;   ch_small.t_data  = d;
    ch_big.t_last  = l;   ch_small.t_last  = l;
    ch_big.t_keep  = keep; ch_small.t_keep = keep;
    ch_big.t_strb  = strb; ch_small.t_strb = strb;
  endtask

  task automatic realign();
    @(posedge aclk);
    #1;
  endtask

  // Present one beat and hold it until it transfers (bounded wait).
  task automatic send_beat(input logic [63:0] d, input logic l,
                           input logic [7:0] keep, input logic [7:0] strb);
    logic acc;
    acc = 1'b0;
    set_bus(1'b1, d, l, keep, strb);
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge aclk);
      acc = ch_big.t_ready;
      @(posedge aclk);
    end
    #1;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    set_bus(1'b0, d, 1'b0, 8'hFF, 8'hFF);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    realign();
    clear = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    ready_rate = 8'hFF;
    check_en   = 1'b1;
    clear      = 1'b0;
    set_bus(1'b0, 64'd0, 1'b0, 8'hFF, 8'hFF);
    ch_big.t_id = '0;   ch_big.t_dest = '0;   ch_big.t_user = '0;
    ch_small.t_id = '0; ch_small.t_dest = '0; ch_small.t_user = '0;

    #1 aresetn = 1'b0;
    checking = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("lit_reset_ready", 64'(ch_big.t_ready), 64'd0);
    chk("lit_reset_word", 64'(wc_b), 64'd0);
    chk("lit_reset_fed", fed_b, 64'd0);
    realign();

    // Three clean 4-beat packets at full rate.
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) send_beat(64'(b), b == 3, 8'hFF, 8'hFF);
    @(negedge aclk);
    chk("lit_t1_word", 64'(wc_b), 64'd12);
    chk("lit_t1_pkt", 64'(pc_b), 64'd3);
    chk("lit_t1_err", 64'(err_b), 64'd0);
    chk("lit_t1_word_small", 64'(wc_s), 64'd12);
    realign();

    // Same traffic, one corrupted beat in the second packet.
    pulse_clear();
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++)
        send_beat((p == 1 && b == 2) ? 64'd7 : 64'(b), b == 3, 8'hFF, 8'hFF);
    @(negedge aclk);
    chk("lit_t2_err", 64'(err_b), 64'd1);
    chk("lit_t2_errc", 64'(ec_b), 64'd1);
    chk("lit_t2_fed", fed_b, 64'd7);
    realign();

    // Never ready: data held for 100 cycles, nothing transfers.
    pulse_clear();
    ready_rate = 8'h00;
    repeat (2) realign();
    rc_cyc = 0; rc_rdy = 0; phase = 3;
    set_bus(1'b1, 64'd5, 1'b1, 8'hFF, 8'hFF);
    repeat (100) realign();
    set_bus(1'b0, 64'd5, 1'b0, 8'hFF, 8'hFF);
    phase = 0;
    @(negedge aclk);
    chk("lit_t3_never_ready", 64'(rc_rdy), 64'd0);
    chk("lit_t3_word", 64'(wc_b), 64'd0);
    realign();

    // Quarter-rate throttle, 1000 single-beat packets of data 0.
    pulse_clear();
    ready_rate = 8'd64;
    rc_cyc = 0; rc_rdy = 0; phase = 4;
    for (int i = 0; i < 1000; i++) send_beat(64'd0, 1'b1, 8'hFF, 8'hFF);
    phase = 0;
    @(negedge aclk);
    chk("lit_t4_pkt", 64'(pc_b), 64'd1000);
    chk("lit_t4_err", 64'(err_b), 64'd0);
    chk("lit_t4_pkt_small_sat", 64'(pc_s), 64'd15);
    chk("lit_t4_fraction", 64'((rc_rdy * 10 >= rc_cyc * 2) && (rc_rdy * 10 <= rc_cyc * 3)), 64'd1);
    realign();

    // One 20-beat packet carrying i mod 16: clean for the 4-bit sink only.
    ready_rate = 8'hFF;
    pulse_clear();
    for (int i = 0; i < 20; i++) send_beat(64'(i % 16), i == 19, 8'hFF, 8'hFF);
    @(negedge aclk);
    chk("lit_t5_word_small_sat", 64'(wc_s), 64'd15);
    chk("lit_t5_err_small", 64'(err_s), 64'd0);
    chk("lit_t5_errc_big", 64'(ec_b), 64'd4);
    chk("lit_t5_pkt_small", 64'(pc_s), 64'd1);
    realign();

    // Partial strobe is an error; with checking off bad data is not.
    pulse_clear();
    send_beat(64'd0, 1'b1, 8'hFF, 8'h7F);
    @(negedge aclk);
    chk("lit_strb_err", 64'(err_b), 64'd1);
    realign();
    pulse_clear();
    check_en = 1'b0;
    send_beat(64'd9, 1'b1, 8'hFF, 8'hFF);
    @(negedge aclk);
    chk("lit_nocheck_err", 64'(err_b), 64'd0);
    chk("lit_nocheck_word", 64'(wc_b), 64'd1);
    realign();
    check_en = 1'b1;

    // Reset in the middle of a packet, then a fresh packet 0,1.
    pulse_clear();
    send_beat(64'd0, 1'b0, 8'hFF, 8'hFF);
    send_beat(64'd1, 1'b0, 8'hFF, 8'hFF);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("lit_rst_ready", 64'(ch_big.t_ready), 64'd0);
    chk("lit_rst_word", 64'(wc_b), 64'd0);
    chk("lit_rst_state", 64'(st_b == BODY), 64'd0);
    realign();
    aresetn = 1'b1;
    send_beat(64'd0, 1'b0, 8'hFF, 8'hFF);
    send_beat(64'd1, 1'b1, 8'hFF, 8'hFF);
    @(negedge aclk);
    chk("lit_rst_pkt", 64'(pc_b), 64'd1);
    chk("lit_rst_err", 64'(err_b), 64'd0);
    realign();

    // Clear together with an accepted beat: the beat is dropped.
    clear = 1'b1;
    send_beat(64'd0, 1'b1, 8'hFF, 8'hFF);
    clear = 1'b0;
    @(negedge aclk);
    chk("lit_clr_word", 64'(wc_b), 64'd0);
    chk("lit_clr_pkt", 64'(pc_b), 64'd0);
    realign();

    repeat (3) realign();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
